alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Decode/operand stage that feeds the 32-bit ALU: holds the 32×32 general-purpose register file, decodes the 2-bit main-control ALU class plus R-type `funct` into the ALU's 4-bit `op` encoding, selects register or immediate for operand B, and registers `A`, `B` and `op` into a one-deep pipeline register whose outputs drive the ALU directly. It includes write-back forwarding into the read ports, stall and flush controls, and an illegal-funct flag.

## Interface
- `DATA_W`, 32: register and operand width; only 32 is supported.
- `ADDR_W`, 5: register address width, giving 32 registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction fields are valid this cycle.
- `rs`, `rt`  in  5  source register addresses.
- `imm`  in  16  instruction immediate.
- `alu_src`  in  1  1: B comes from the extended `imm`; 0: B comes from `rt`.
- `alu_op`  in  2  ALU class: 00 add, 01 sub, 10 R-type (use `funct`), 11 or-immediate.
- `funct`  in  6  R-type function field.
- `stall`  in  1  hold the pipeline register.
- `flush`  in  1  kill the pipeline register contents.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  5  write address.
- `wb_data`  in  32  write data.
- `out_valid`  out  1  `A`, `B` and `op` hold a live instruction.
- `A`, `B`  out  32  ALU operands.
- `op`  out  4  ALU operation code.
- `illegal`  out  1  unsupported `funct` with `alu_op`=10.

## Operation
- Register file
  - 32 entries × 32 bits, with two combinational read ports and one write port.
  - The write occurs on the clock edge when `wb_en`=1 and `wb_addr`≠0. It is independent of `stall` and `flush`.
  - Register 0 always reads 0. Writes to register 0 are discarded.
  - Forwarding: if `wb_en`=1, `wb_addr`=`rs` and `rs`≠0, then read port A returns `wb_data` in the same cycle. The same rule applies to `rt` on read port B.
- Immediate extension
  - `alu_op`=11: zero-extend `imm`.
  - Otherwise: sign-extend `imm`.
- B select: `alu_src`=1 selects the extended immediate; otherwise the `rt` read value.
- Op decode
  - `alu_op`=00 → 0010.
  - `alu_op`=01 → 0110.
  - `alu_op`=11 → 0001.
  - `alu_op`=10, by `funct`: 100100 → 0000 (AND), 100101 → 0001 (OR), 100000 → 0010 (ADD), 100010 → 0110 (SUB), 101010 → 0111 (SLT), 100111 → 1100 (NOR).
  - `alu_op`=10 with any other `funct` → op 1111 and `illegal`=1. The ALU returns 0 for op 1111.
- Pipeline register update, in priority order:
  1. `rst`: `out_valid`, `A`, `B`, `op` and `illegal` all go to 0. All 32 registers clear to 0. A simultaneous write-back is ignored.
  2. `flush`: `out_valid`=0 and `A`/`B`/`op`/`illegal` are cleared to 0. Flush overrides `stall`.
  3. `stall`: all outputs hold their values. Input fields are discarded and must be re-presented by upstream.
  4. Otherwise: `out_valid` ← `in_valid`, and `A`/`B`/`op`/`illegal` load the decoded values. When `in_valid`=0, the fields still load but are don't-care.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Write-to-read: a write at edge N is visible at edge N through the forwarding path, and from the array after edge N.
- Reset takes effect at the first rising edge with `rst`=1. A reset asserted mid-stream drops the in-flight instruction.
- A stall of any length keeps the outputs stable. Write-backs during a stall update the array but not the held operands.
- Simultaneous `stall`, `flush` and `in_valid`: flush wins and `out_valid`=0 on the next cycle.

## Test plan
1. Reset: write r5=0x00000007, then assert `rst` for one cycle → all outputs are 0. A following read of r5 with `alu_op`=10 and `funct`=100000 gives A=0x00000000.
2. R-type SUB: preload r5=7 and r6=3, then `in_valid`=1, `rs`=5, `rt`=6, `alu_op`=10, `funct`=100010 → next cycle A=0x7, B=0x3, op=0110, `out_valid`=1, `illegal`=0.
3. Forwarding and r0:
   - `wb_en`=1, `wb_addr`=9, `wb_data`=0xDEADBEEF in the same cycle as `rs`=9 → A=0xDEADBEEF.
   - Write r0=0x1234, then read `rs`=0 → A=0 in both the forwarding case and the array case.
4. Immediates:
   - `alu_op`=00, `alu_src`=1, `imm`=0xFFFC → B=0xFFFFFFFC, op=0010.
   - `alu_op`=11, `imm`=0x8000 → B=0x00008000, op=0001.
5. Stall and flush:
   - Assert `stall` for 3 cycles while the inputs change → outputs are unchanged.
   - Assert `stall`+`flush` together → next cycle `out_valid`=0 and A=B=op=0.
6. Illegal funct: `alu_op`=10, `funct`=000000 → op=1111, `illegal`=1, `out_valid`=1. A following legal instruction clears `illegal`.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decode/operand stage bundle: instruction fields, controls, write-back and ALU-side outputs
interface alu_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [15:0]       imm;
  logic              alu_src;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [3:0]        op;
  logic              illegal;

  // Upstream/write-back side: drives fields and controls, observes the ALU-facing register
  modport master (
    output in_valid, rs, rt, imm, alu_src, alu_op, funct,
    output stall, flush, wb_en, wb_addr, wb_data,
    input  out_valid, A, B, op, illegal
  );

  // The operand stage itself
  modport slave (
    input  in_valid, rs, rt, imm, alu_src, alu_op, funct,
    input  stall, flush, wb_en, wb_addr, wb_data,
    output out_valid, A, B, op, illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register file, op decode, operand select and one-deep pipeline register feeding the ALU
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                i_clk,
  input logic                i_rst,
  alu_operand_stage_if.slave bus
);
  localparam int N_REGS = 1 << ADDR_W;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  logic [DATA_W-1:0] r_regs [N_REGS];

  logic              r_valid;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_op;
  logic              r_illegal;

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_b_sel;
  logic [3:0]        w_op;
  logic              w_illegal;
  logic              w_wb_live;

  // A write to r0 is never performed, so r0 is also excluded from forwarding
  assign w_wb_live = bus.wb_en && (bus.wb_addr != '0);

  // Register array: cleared by reset, written by write-back regardless of stall/flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read ports: r0 is hard zero; a same-cycle write-back to the read address bypasses the array
  always_comb begin
    w_rd_a = r_regs[bus.rs];
    if (bus.rs == '0) begin
      w_rd_a = '0;
    end else if (w_wb_live && (bus.wb_addr == bus.rs)) begin
      w_rd_a = bus.wb_data;
    end

    w_rd_b = r_regs[bus.rt];
    if (bus.rt == '0) begin
      w_rd_b = '0;
    end else if (w_wb_live && (bus.wb_addr == bus.rt)) begin
      w_rd_b = bus.wb_data;
    end
  end

  // Immediate extension (zero-extend only for or-immediate) and operand B select
  always_comb begin
    w_imm_ext = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
    if (bus.alu_op == 2'b11) begin
      w_imm_ext = {{(DATA_W-16){1'b0}}, bus.imm};
    end
    w_b_sel = bus.alu_src ? w_imm_ext : w_rd_b;
  end

  // Main-control class plus funct decoded into the ALU op code; unknown funct maps to the zero-result op
  always_comb begin
    w_op      = OP_ADD;
    w_illegal = 1'b0;
    case (bus.alu_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b11: w_op = OP_OR;
      default: begin
        case (bus.funct)
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100000: w_op = OP_ADD;
          6'b100010: w_op = OP_SUB;
          6'b101010: w_op = OP_SLT;
          6'b100111: w_op = OP_NOR;
          default: begin
            w_op      = OP_BAD;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Pipeline register: reset, then flush (beats stall), then stall hold, else load
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.flush) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else if (!bus.stall) begin
      r_valid   <= bus.in_valid;
      r_a       <= w_rd_a;
      r_b       <= w_b_sel;
      r_op      <= w_op;
      r_illegal <= w_illegal;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign bus.op        = r_op;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed vector table plus hand sequences for reset, forwarding, stall and flush
module tb_alu_operand_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        in_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        chk_fields;
    logic        exp_valid;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] o, input logic il);
    chk({name, ".valid"},   {31'd0, bus.out_valid}, {31'd0, v});
    chk({name, ".A"},       bus.A, a);
    chk({name, ".B"},       bus.B, b);
    chk({name, ".op"},      {28'd0, bus.op}, {28'd0, o});
    chk({name, ".illegal"}, {31'd0, bus.illegal}, {31'd0, il});
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.rs       = '0;
    bus.rt       = '0;
    bus.imm      = '0;
    bus.alu_src  = 1'b0;
    bus.alu_op   = 2'b00;
    bus.funct    = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                       input logic src, input logic [1:0] aop, input logic [5:0] fn);
    bus.in_valid = 1'b1;
    bus.rs       = rs;
    bus.rt       = rt;
    bus.imm      = imm;
    bus.alu_src  = src;
    bus.alu_op   = aop;
    bus.funct    = fn;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    idle();
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  task automatic add_vec(input string name, input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic src, input logic [1:0] aop,
                         input logic [5:0] fn, input logic cf, input logic ev,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] eo,
                         input logic ei);
    vec_t v;
    v.name = name; v.in_valid = iv; v.rs = rs; v.rt = rt; v.imm = imm; v.alu_src = src;
    v.alu_op = aop; v.funct = fn; v.chk_fields = cf; v.exp_valid = ev;
    v.exp_a = ea; v.exp_b = eb; v.exp_op = eo; v.exp_ill = ei;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // r5=7, r6=3, r7=-1, r10=0x80000000 are preloaded before the table runs
    add_vec("sub",      1, 5, 6, 16'h0000, 0, 2'b10, 6'b100010, 1, 1, 32'h7, 32'h3, 4'b0110, 0);
    add_vec("add",      1, 5, 7, 16'h0000, 0, 2'b10, 6'b100000, 1, 1, 32'h7, 32'hFFFFFFFF, 4'b0010, 0);
    add_vec("and",      1, 6, 5, 16'h0000, 0, 2'b10, 6'b100100, 1, 1, 32'h3, 32'h7, 4'b0000, 0);
    add_vec("or",       1, 10, 6, 16'h0000, 0, 2'b10, 6'b100101, 1, 1, 32'h80000000, 32'h3, 4'b0001, 0);
    add_vec("slt",      1, 7, 5, 16'h0000, 0, 2'b10, 6'b101010, 1, 1, 32'hFFFFFFFF, 32'h7, 4'b0111, 0);
    add_vec("nor",      1, 5, 6, 16'h0000, 0, 2'b10, 6'b100111, 1, 1, 32'h7, 32'h3, 4'b1100, 0);
    add_vec("addi_neg", 1, 5, 6, 16'hFFFC, 1, 2'b00, 6'b000000, 1, 1, 32'h7, 32'hFFFFFFFC, 4'b0010, 0);
    add_vec("ori_zext", 1, 6, 5, 16'h8000, 1, 2'b11, 6'b000000, 1, 1, 32'h3, 32'h00008000, 4'b0001, 0);
    add_vec("sub_imm",  1, 5, 0, 16'h8000, 1, 2'b01, 6'b000000, 1, 1, 32'h7, 32'hFFFF8000, 4'b0110, 0);
    add_vec("sub_reg",  1, 6, 5, 16'h1234, 0, 2'b01, 6'b100000, 1, 1, 32'h3, 32'h7, 4'b0110, 0);
    add_vec("illegal",  1, 5, 6, 16'h0000, 0, 2'b10, 6'b000000, 1, 1, 32'h7, 32'h3, 4'b1111, 1);
    add_vec("ill_clr",  1, 6, 6, 16'h0000, 0, 2'b10, 6'b100000, 1, 1, 32'h3, 32'h3, 4'b0010, 0);
    add_vec("r0_read",  1, 0, 0, 16'h0000, 0, 2'b10, 6'b100101, 1, 1, 32'h0, 32'h0, 4'b0001, 0);
    add_vec("bubble",   0, 5, 6, 16'h0000, 0, 2'b10, 6'b100010, 0, 0, 32'h0, 32'h0, 4'b0000, 0);

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset clears array and outputs
    wb_write(5, 32'h00000007);
    instr(5, 5, 16'h0, 0, 2'b10, 6'b100000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("reset", 0, 32'h0, 32'h0, 4'h0, 0);
    instr(5, 0, 16'h0, 0, 2'b10, 6'b100000);
    tick();
    chk_all("post_reset_r5", 1, 32'h0, 32'h0, 4'b0010, 0);

    wb_write(5, 32'h00000007);
    wb_write(6, 32'h00000003);
    wb_write(7, 32'hFFFFFFFF);
    wb_write(10, 32'h80000000);

    foreach (vecs[i]) begin
      idle();
      instr(vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].alu_src, vecs[i].alu_op, vecs[i].funct);
      bus.in_valid = vecs[i].in_valid;
      tick();
      if (vecs[i].chk_fields) begin
        chk_all(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_op, vecs[i].exp_ill);
      end else begin
        chk({vecs[i].name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, vecs[i].exp_valid});
      end
    end

    // Same-cycle forwarding on both ports, then the array value
    idle();
    instr(9, 9, 16'h0, 0, 2'b10, 6'b100101);
    bus.wb_en = 1'b1; bus.wb_addr = 9; bus.wb_data = 32'hDEADBEEF;
    tick();
    chk_all("fwd", 1, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0001, 0);
    idle();
    instr(9, 6, 16'h0, 0, 2'b10, 6'b100000);
    tick();
    chk_all("fwd_array", 1, 32'hDEADBEEF, 32'h3, 4'b0010, 0);

    // Write to r0: neither forwarded nor stored
    idle();
    instr(0, 0, 16'h0, 0, 2'b10, 6'b100000);
    bus.wb_en = 1'b1; bus.wb_addr = 0; bus.wb_data = 32'h00001234;
    tick();
    chk_all("r0_fwd", 1, 32'h0, 32'h0, 4'b0010, 0);
    idle();
    instr(0, 0, 16'h0, 0, 2'b10, 6'b100000);
    tick();
    chk_all("r0_array", 1, 32'h0, 32'h0, 4'b0010, 0);

    // Stall for three cycles with changing inputs and a write-back to r5
    idle();
    instr(5, 6, 16'h0, 0, 2'b10, 6'b100010);
    tick();
    chk_all("pre_stall", 1, 32'h7, 32'h3, 4'b0110, 0);
    for (int c = 0; c < 3; c++) begin
      idle();
      instr(6, 7, 16'h1111 + 16'(c), c[0], 2'b11, 6'b000000);
      bus.stall = 1'b1;
      if (c == 1) begin
        bus.wb_en = 1'b1; bus.wb_addr = 5; bus.wb_data = 32'h00000055;
      end
      tick();
      chk_all($sformatf("stall%0d", c), 1, 32'h7, 32'h3, 4'b0110, 0);
    end
    idle();
    instr(5, 5, 16'h0, 0, 2'b10, 6'b100000);
    tick();
    chk_all("after_stall", 1, 32'h55, 32'h55, 4'b0010, 0);

    // Stall + flush + valid: flush wins
    idle();
    instr(5, 6, 16'h0, 0, 2'b10, 6'b000000);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    chk_all("stall_flush", 0, 32'h0, 32'h0, 4'h0, 0);

    // Mid-stream reset drops the in-flight instruction
    idle();
    instr(5, 6, 16'h0, 0, 2'b10, 6'b000000);
    tick();
    chk_all("pre_rst_ill", 1, 32'h55, 32'h3, 4'b1111, 1);
    instr(6, 6, 16'h0, 0, 2'b10, 6'b100000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("mid_rst", 0, 32'h0, 32'h0, 4'h0, 0);
    idle();
    instr(6, 5, 16'h0, 0, 2'b10, 6'b100000);
    tick();
    chk_all("mid_rst_array", 1, 32'h0, 32'h0, 4'b0010, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
